// File: rtl/mux_nto1_reg.sv
// rtl/mux_nto1_reg.sv - registered N-to-1 mux with select validation, channel echo and optional auto-scan (MUX_SCAN_EN)
module mux_nto1_reg #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    sel_err
);

    // One extra bit so N_CH == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] cur_sel_q;
    logic [SEL_W-1:0] next_sel;
    logic             sel_ok;
    logic             sel_bad;
    logic [WIDTH-1:0] out_data_d;

    assign sel_ok  = sel_valid && ({1'b0, sel} < N_CH_W);
    assign sel_bad = sel_valid && !sel_ok;

`ifdef MUX_SCAN_EN
    typedef enum logic {MANUAL, SCAN} state_t;

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    state_t          state_q;
    logic [DW_W-1:0] dwell_q;
    logic [DW_W-1:0] dwell_d;

    // Channel choice: a valid request wins, otherwise scan steps at the end of each dwell.
    // Leaving SCAN (mode low) behaves as manual, which holds the channel and clears dwell.
    always_comb begin
        next_sel = cur_sel_q;
        dwell_d  = '0;
        if (sel_ok) begin
            next_sel = sel;
        end else if (state_q == SCAN && mode) begin
            if (dwell_q == DWELL_LAST) begin
                next_sel = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + 1'b1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Mode FSM and dwell counter; reset drops any scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
            case (state_q)
                MANUAL:  if (mode)  state_q <= SCAN;
                SCAN:    if (!mode) state_q <= MANUAL;
                default: state_q <= MANUAL;
            endcase
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Manual only: a valid request moves the selection, anything else holds it.
    always_comb begin
        next_sel = cur_sel_q;
        if (sel_ok) begin
            next_sel = sel;
        end
    end
`endif

    // Data path mux on the channel that will be registered this edge.
    always_comb begin
        out_data_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (next_sel == SEL_W'(i)) begin
                out_data_d = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output registers: live data every cycle, channel echo, one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sel_q <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
        end else begin
            cur_sel_q <= next_sel;
            out_data  <= out_data_d;
            out_valid <= 1'b1;
            out_ch    <= next_sel;
            sel_err   <= sel_bad;
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb/tb_mux_nto1_reg.sv - vector table, directed corner cases and randomized model check for mux_nto1_reg
module tb_mux_nto1_reg;

`ifdef MUX_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic        sel_valid;
    logic        mode;

    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid;
    logic [1:0]  a_ch, b_ch;
    logic        a_err, b_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_nto1_reg #(.N_CH(4), .WIDTH(8), .SEL_W(2), .DWELL(DWELL)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .sel_valid(sel_valid),
        .mode(mode), .out_data(a_data), .out_valid(a_valid), .out_ch(a_ch), .sel_err(a_err)
    );

    mux_nto1_reg #(.N_CH(3), .WIDTH(8), .SEL_W(2), .DWELL(DWELL)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data[23:0]), .sel(sel), .sel_valid(sel_valid),
        .mode(mode), .out_data(b_data), .out_valid(b_valid), .out_ch(b_ch), .sel_err(b_err)
    );

    // Reference model: per instance, the channel in use, scan flag and dwell position.
    int n_ch [2] = '{4, 3};
    int m_cur[2], m_dw[2], m_scan[2], m_data[2], m_ch[2], m_val[2], m_err[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cur[k] = 0; m_dw[k] = 0; m_scan[k] = 0;
                m_data[k] = 0; m_ch[k] = 0; m_val[k] = 0; m_err[k] = 0;
            end else begin
                int  ch;
                bit  jumped;
                ch = m_cur[k];
                jumped = 0;
                m_err[k] = 0;
                if (sel_valid && int'(sel) < n_ch[k]) begin
                    ch = int'(sel);
                    jumped = 1;
                end else if (sel_valid) begin
                    m_err[k] = 1;
                end
                if (SCAN_EN && m_scan[k] == 1 && mode) begin
                    if (jumped) m_dw[k] = 0;
                    else if (m_dw[k] == DWELL - 1) begin
                        ch = (m_cur[k] + 1) % n_ch[k];
                        m_dw[k] = 0;
                    end else m_dw[k] = m_dw[k] + 1;
                end else begin
                    m_dw[k] = 0;
                end
                m_scan[k] = SCAN_EN ? int'(mode) : 0;
                m_cur[k]  = ch;
                m_ch[k]   = ch;
                m_data[k] = int'((in_data >> (8 * ch)) & 32'hFF);
                m_val[k]  = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".a_data"},  int'(a_data),  m_data[0]);
        check({tag, ".a_valid"}, int'(a_valid), m_val[0]);
        check({tag, ".a_ch"},    int'(a_ch),    m_ch[0]);
        check({tag, ".a_err"},   int'(a_err),   m_err[0]);
        check({tag, ".b_data"},  int'(b_data),  m_data[1]);
        check({tag, ".b_valid"}, int'(b_valid), m_val[1]);
        check({tag, ".b_ch"},    int'(b_ch),    m_ch[1]);
        check({tag, ".b_err"},   int'(b_err),   m_err[1]);
    endtask

    // Drive inputs, take one edge, update the model, sample 1 time unit later.
    task automatic cycle(input logic r, input logic [31:0] d, input logic [1:0] s,
                         input logic sv, input logic m);
        rst = r; in_data = d; sel = s; sel_valid = sv; mode = m;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic [1:0]  sel;
        logic        sv;
        logic [7:0]  exp_data;
        logic        exp_valid;
        logic [1:0]  exp_ch;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1; in_data = '0; sel = '0; sel_valid = 1'b0; mode = 1'b0;

        // Reset, manual selection sequence, hold, and live data tracking (instance u_a).
        vecs.push_back('{1'b1, 32'hDDCCBBAA, 2'd0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 32'hDDCCBBAA, 2'd0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd2, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd1, 1'b1, 8'hBB, 1'b1, 2'd1, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd3, 1'b1, 8'hDD, 1'b1, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 8'hDD, 1'b1, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd1, 1'b0, 8'hDD, 1'b1, 2'd3, 1'b0});
        vecs.push_back('{1'b0, 32'hDDCCBBAA, 2'd2, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0});
        vecs.push_back('{1'b0, 32'hDD5ABBAA, 2'd0, 1'b0, 8'h5A, 1'b1, 2'd2, 1'b0});
        vecs.push_back('{1'b0, 32'h115A2233, 2'd1, 1'b0, 8'h5A, 1'b1, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 32'h115A2233, 2'd1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].din, vecs[i].sel, vecs[i].sv, 1'b0);
            check($sformatf("vec%0d.data", i),  int'(a_data),  int'(vecs[i].exp_data));
            check($sformatf("vec%0d.valid", i), int'(a_valid), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d.ch", i),    int'(a_ch),    int'(vecs[i].exp_ch));
            check($sformatf("vec%0d.err", i),   int'(a_err),   int'(vecs[i].exp_err));
            check_model($sformatf("vec%0d", i));
        end

        // Rejected select on the 3-channel instance: one-cycle error pulse, selection kept.
        cycle(1'b0, 32'h00332211, 2'd1, 1'b1, 1'b0);
        check("inv.pre_ch", int'(b_ch), 1);
        cycle(1'b0, 32'h00332211, 2'd3, 1'b1, 1'b0);
        check("inv.err",  int'(b_err),  1);
        check("inv.ch",   int'(b_ch),   1);
        check("inv.data", int'(b_data), 8'h22);
        check("inv.a_ch", int'(a_ch),   3);
        cycle(1'b0, 32'h00332211, 2'd0, 1'b0, 1'b0);
        check("inv.err_clear", int'(b_err), 0);
        check("inv.ch_held",   int'(b_ch),  1);
        check_model("inv");

`ifdef MUX_SCAN_EN
        // Scan from channel 0: four cycles per channel, wrapping.
        cycle(1'b1, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1);
            check($sformatf("scan%0d.ch", i), int'(a_ch), (i / DWELL) % 4);
            check_model($sformatf("scan%0d", i));
        end
        // Jump mid-dwell to channel 2, then a full dwell there before stepping.
        cycle(1'b0, 32'hDDCCBBAA, 2'd2, 1'b1, 1'b1);
        check("jump.ch", int'(a_ch), 2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1);
            check($sformatf("jump_hold%0d", i), int'(a_ch), 2);
        end
        cycle(1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1);
        check("jump.step", int'(a_ch), 3);
        // Reset while scanning on channel 3, release into manual.
        cycle(1'b1, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1);
        check("scanrst.data",  int'(a_data),  0);
        check("scanrst.valid", int'(a_valid), 0);
        check("scanrst.ch",    int'(a_ch),    0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b0);
            check($sformatf("scanrst_man%0d", i), int'(a_ch), 0);
        end
        check_model("scanrst");
`endif

        // Randomized traffic against the model, both instances.
        begin
            logic m;
            m = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                cycle(($urandom_range(0, 49) == 0), $urandom,
                      2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), m);
                check_model($sformatf("rnd%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
